// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI responder.
package adc_spi_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall pulses
// derived from the synchronized level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(d_i);
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating a CNV-triggered SAR ADC. Optional MOSI capture into
// cfg_o is enabled by defining ADC_SPI_RESPONDER_MOSI_CAPTURE_EN.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned CONV_CYCLES = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic             cnv_i,
  input  logic             spi_clk_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  output logic             busy_o,
  output logic             frame_done_o,
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
  output logic [WIDTH-1:0] cfg_o,
`endif
  output logic             overrun_o
);

  localparam int unsigned CW = $clog2(CONV_CYCLES + 1);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  logic cnv_level, cnv_rise, cnv_fall;
  logic clk_level, clk_rise, clk_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cnv (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(cnv_i),
    .level_o(cnv_level), .rise_o(cnv_rise), .fall_o(cnv_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_clk_i),
    .level_o(clk_level), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] staging_q, staging_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    conv_cnt_q, conv_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
  logic             mosi_level, mosi_rise, mosi_fall;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] cfg_q, cfg_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_mosi_i),
    .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{cnv_level, cnv_fall, clk_level, mosi_rise, mosi_fall};
`else
  logic unused_edges;
  assign unused_edges = ^{cnv_level, cnv_fall, clk_level, clk_rise, spi_mosi_i};
`endif

  always_comb begin
    state_d    = state_q;
    staging_d  = sample_valid_i ? sample_i : staging_q;
    shift_d    = shift_q;
    conv_cnt_d = conv_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
    cap_d      = cap_q;
    cfg_d      = cfg_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cnv_rise) begin
          state_d    = ST_CONVERT;
          shift_d    = staging_q;
          conv_cnt_d = '0;
        end else if (clk_fall) begin
          overrun_d = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (cnv_rise) begin
          overrun_d  = 1'b1;
          shift_d    = staging_q;
          conv_cnt_d = '0;
        end else if (conv_cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d   = ST_SHIFT;
          miso_d    = shift_q[WIDTH-1];
          bit_cnt_d = '0;
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
          cap_d     = '0;
`endif
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // cnv restart outranks any spi_clk edge seen in the same cycle
        if (cnv_rise) begin
          overrun_d  = 1'b1;
          state_d    = ST_CONVERT;
          shift_d    = staging_q;
          conv_cnt_d = '0;
          miso_d     = 1'b0;
        end else if (clk_fall) begin
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            miso_d  = 1'b0;
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
            cfg_d   = cap_q;
`endif
          end else begin
            shift_d   = shift_q << 1;
            miso_d    = shift_d[WIDTH-1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
        else if (clk_rise) begin
          cap_d = (cap_q << 1) | WIDTH'(mosi_level);
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CONVERT) || (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      staging_q  <= '0;
      shift_q    <= '0;
      conv_cnt_q <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
      cap_q      <= '0;
      cfg_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      staging_q  <= staging_d;
      shift_q    <= shift_d;
      conv_cnt_q <= conv_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
      cap_q      <= cap_d;
      cfg_q      <= cfg_d;
`endif
    end
  end

  assign spi_miso_o   = miso_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign overrun_o    = overrun_q;
`ifdef ADC_SPI_RESPONDER_MOSI_CAPTURE_EN
  assign cfg_o        = cfg_q;
`endif

endmodule
